// File: rtl/pattern_gen.sv
// rtl/pattern_gen.sv - serial MSB-first pattern transmitter with repeat count, idle gap and ready backpressure
//
// Ports:
//   clk      - clock, all logic on posedge
//   rst      - synchronous active-high reset
//   start    - run request, sampled only while idle
//   rpt      - number of pattern repetitions, latched on accepted start
//   gap      - idle cycles between repetitions, latched on accepted start
//   ready    - downstream accepts the presented bit when valid && ready
//   out      - serial data bit (registered)
//   valid    - out is meaningful (registered)
//   busy     - high from accepted start until the final bit is accepted
//   done     - one-cycle completion pulse
//   sent_cnt - completed repetitions in the current/last run
module pattern_gen #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int               CNT_W   = 8,
    parameter int               GAP_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] rpt,
    input  logic [GAP_W-1:0] gap,
    input  logic             ready,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent_cnt
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0] rpt_q, rpt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] sent_q, sent_d;
    logic             out_q, out_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] sent_inc;
    logic [IDX_W-1:0] idx_dec;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            gap_cnt_q <= '0;
            rpt_q     <= '0;
            gap_q     <= '0;
            sent_q    <= '0;
            out_q     <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            gap_cnt_q <= gap_cnt_d;
            rpt_q     <= rpt_d;
            gap_q     <= gap_d;
            sent_q    <= sent_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state and next-output computation
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        gap_cnt_d = gap_cnt_q;
        rpt_d     = rpt_q;
        gap_d     = gap_q;
        sent_d    = sent_q;
        out_d     = out_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sent_inc  = sent_q + CNT_W'(1);
        idx_dec   = idx_q - IDX_W'(1);

        case (state_q)
            IDLE: begin
                out_d   = 1'b0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    rpt_d  = rpt;
                    gap_d  = gap;
                    sent_d = '0;
                    if (rpt != '0) begin
                        state_d = SHIFT;
                        idx_d   = IDX_MSB;
                        out_d   = PATTERN[PAT_W-1];
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        // Empty run: completes immediately without ever asserting valid.
                        done_d = 1'b1;
                    end
                end
            end

            SHIFT: begin
                if (valid_q && ready) begin
                    if (idx_q != '0) begin
                        idx_d = idx_dec;
                        out_d = PATTERN[idx_dec];
                    end else begin
                        sent_d = sent_inc;
                        idx_d  = IDX_MSB;
                        if (sent_inc == rpt_q) begin
                            state_d = IDLE;
                            out_d   = 1'b0;
                            valid_d = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else if (gap_q == '0) begin
                            // Back-to-back repetition: valid stays high.
                            out_d = PATTERN[PAT_W-1];
                        end else begin
                            state_d   = GAP;
                            out_d     = 1'b0;
                            valid_d   = 1'b0;
                            gap_cnt_d = gap_q;
                        end
                    end
                end
            end

            GAP: begin
                // gap_cnt counts the remaining low-valid cycles including this one.
                if (gap_cnt_q <= GAP_W'(1)) begin
                    state_d   = SHIFT;
                    gap_cnt_d = '0;
                    idx_d     = IDX_MSB;
                    out_d     = PATTERN[PAT_W-1];
                    valid_d   = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                out_d   = 1'b0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Outputs come straight from registers
    always_comb begin
        out      = out_q;
        valid    = valid_q;
        busy     = busy_q;
        done     = done_q;
        sent_cnt = sent_q;
    end

endmodule

// File: tb/tb_pattern_gen.sv
// tb/tb_pattern_gen.sv - self-checking bench for pattern_gen
module tb_pattern_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] rpt_in = 8'd0;
    logic [3:0] gap_in = 4'd0;
    logic       ready = 1'b1;
    logic       out;
    logic       valid;
    logic       busy;
    logic       done;
    logic [7:0] sent_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pattern_gen #(
        .PAT_W  (4),
        .PATTERN(4'b1011),
        .CNT_W  (8),
        .GAP_W  (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .rpt     (rpt_in),
        .gap     (gap_in),
        .ready   (ready),
        .out     (out),
        .valid   (valid),
        .busy    (busy),
        .done    (done),
        .sent_cnt(sent_cnt)
    );

    // Reference 1011 overlapping detector fed by accepted bits
    logic       det_clr = 1'b0;
    logic [3:0] det_sh = 4'd0;
    int         det_cnt = 0;
    int         valid_cnt = 0;

    always @(posedge clk) begin
        if (det_clr) begin
            det_sh    = 4'd0;
            det_cnt   = 0;
            valid_cnt = 0;
        end else if (!rst && valid && ready) begin
            det_sh = {det_sh[2:0], out};
            valid_cnt = valid_cnt + 1;
            if (det_sh == 4'b1011) det_cnt = det_cnt + 1;
        end
    end

    typedef struct {
        logic       out;
        logic       valid;
        logic       busy;
        logic       done;
        logic [7:0] sent;
        logic       rdy;
    } exp_t;

    typedef struct {
        int rpt;
        int gap;
        int bp;
        int restart_at;
    } case_t;

    exp_t sb_q[$];

    task automatic check(input string name, input int cyc, input exp_t e);
        tests++;
        if (out !== e.out || valid !== e.valid || busy !== e.busy ||
            done !== e.done || sent_cnt !== e.sent) begin
            fails++;
            $display("FAIL %s cyc %0d: got out=%b valid=%b busy=%b done=%b sent=%0d, want out=%b valid=%b busy=%b done=%b sent=%0d",
                     name, cyc, out, valid, busy, done, sent_cnt,
                     e.out, e.valid, e.busy, e.done, e.sent);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Expected cycle-by-cycle trace of one run, starting the cycle after start
    task automatic push_run(input int rpt, input int gap, input int bp);
        logic [3:0] pat;
        int         sent;
        exp_t       e;
        pat  = 4'b1011;
        sent = 0;
        if (rpt == 0) begin
            e = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b1};
            sb_q.push_back(e);
        end else begin
            for (int r = 0; r < rpt; r++) begin
                for (int b = 0; b < 4; b++) begin
                    e = '{pat[3-b], 1'b1, 1'b1, 1'b0, 8'(sent), 1'b0};
                    if (r == 0 && b == 1)
                        for (int k = 0; k < bp; k++) sb_q.push_back(e);
                    e.rdy = 1'b1;
                    sb_q.push_back(e);
                end
                sent++;
                if (r < rpt - 1)
                    for (int g = 0; g < gap; g++) begin
                        // ready deliberately low in the gap
                        e = '{1'b0, 1'b0, 1'b1, 1'b0, 8'(sent), 1'b0};
                        sb_q.push_back(e);
                    end
            end
            e = '{1'b0, 1'b0, 1'b0, 1'b1, 8'(sent), 1'b1};
            sb_q.push_back(e);
        end
        e = '{1'b0, 1'b0, 1'b0, 1'b0, 8'(sent), 1'b1};
        sb_q.push_back(e);
    endtask

    task automatic run_case(input string name, input case_t c);
        exp_t e;
        int   n;
        @(negedge clk);
        start   = 1'b1;
        rpt_in  = 8'(c.rpt);
        gap_in  = 4'(c.gap);
        det_clr = 1'b1;
        push_run(c.rpt, c.gap, c.bp);
        n = 0;
        while (sb_q.size() != 0) begin
            @(negedge clk);
            start   = 1'b0;
            det_clr = 1'b0;
            e = sb_q.pop_front();
            check(name, n, e);
            ready = e.rdy;
            if (n == c.restart_at) begin
                // start while busy must be ignored
                start  = 1'b1;
                rpt_in = 8'd7;
                gap_in = 4'd0;
            end
            n++;
        end
        check_int({name, " det"}, det_cnt, c.rpt);
        check_int({name, " nvalid"}, valid_cnt, c.rpt * 4);
    endtask

    case_t cases[8];

    initial begin
        exp_t z;
        cases[0] = '{1, 0, 0, -1};
        cases[1] = '{3, 2, 0, -1};
        cases[2] = '{2, 0, 0, -1};
        cases[3] = '{1, 0, 3, -1};
        cases[4] = '{0, 0, 0, -1};
        cases[5] = '{2, 1, 0, 2};
        cases[6] = '{4, 1, 2, -1};
        cases[7] = '{2, 15, 0, 6};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        z = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1};
        check("reset", 0, z);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_case($sformatf("case%0d", i), cases[i]);
        end

        // Reset during the second repetition
        @(negedge clk);
        start  = 1'b1;
        rpt_in = 8'd3;
        gap_in = 4'd1;
        ready  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check_int("midrun busy", int'(busy), 1);
        check_int("midrun sent", int'(sent_cnt), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrun rst", 0, z);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post rst idle", k, z);
        end
        run_case("after rst", '{1, 0, 0, -1});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
